// File: rtl/fetch_stage.sv
// IF stage with IF/ID register: owns the PC, fetches one instruction at a time over a
// valid/ready memory port, applies ID redirects and holds a one-entry skid for stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  MAX_WAIT = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic [1:0]  jump,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [5:0]  ifid_opcode,
  output logic [5:0]  ifid_func,
  output logic [31:0] ifid_pc4,
  output logic        imem_timeout
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        squash;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc4;
  logic [7:0]  wait_cnt;
  logic        redirect;
  logic [31:0] target;

  always_comb begin
    redirect = 1'b0;
    target   = '0;
    if (branch_taken) begin
      redirect = 1'b1;
      target   = branch_target;
    end else if (jump == 2'b10) begin
      redirect = 1'b1;
      target   = jr_target & ~32'h3;
    end else if (jump == 2'b01) begin
      redirect = 1'b1;
      target   = {ifid_pc4[31:28], jump_index, 2'b00};
    end
  end

  // State resets to REQ, so the request is masked while reset is held.
  assign imem_req_valid = rst_n && (state == S_REQ);
  assign imem_req_addr  = pc;
  assign ifid_opcode    = ifid_instr[31:26];
  assign ifid_func      = ifid_instr[5:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      squash       <= 1'b0;
      skid_instr   <= '0;
      skid_pc4     <= '0;
      wait_cnt     <= '0;
      ifid_valid   <= 1'b0;
      ifid_instr   <= '0;
      ifid_pc4     <= '0;
      imem_timeout <= 1'b0;
    end else begin
      if (state == S_WAIT && !imem_rsp_valid) begin
        if (wait_cnt == MAX_WAIT)
          imem_timeout <= 1'b1;
        else
          wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= '0;
      end

      if (redirect) begin
        pc         <= target;
        ifid_valid <= 1'b0;
        ifid_instr <= '0;
        case (state)
          // A response landing on the redirect edge is the stale one; nothing is left
          // outstanding, so fetch restarts immediately instead of waiting to squash.
          S_WAIT: begin
            if (imem_rsp_valid) begin
              squash <= 1'b0;
              state  <= S_REQ;
            end else begin
              squash <= 1'b1;
            end
          end
          S_REQ: begin
            if (imem_req_ready) begin
              squash <= 1'b1;
              state  <= S_WAIT;
            end
          end
          default: state <= S_REQ;
        endcase
      end else begin
        if (!stall) begin
          ifid_valid <= 1'b0;
          ifid_instr <= '0;
        end
        case (state)
          S_REQ: begin
            if (imem_req_ready) begin
              pc    <= pc + 32'd4;
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              if (squash) begin
                squash <= 1'b0;
                state  <= S_REQ;
              end else if (stall) begin
                skid_instr <= imem_rsp_data;
                skid_pc4   <= pc;
                state      <= S_FULL;
              end else begin
                ifid_valid <= 1'b1;
                ifid_instr <= imem_rsp_data;
                ifid_pc4   <= pc;
                state      <= S_REQ;
              end
            end
          end
          S_FULL: begin
            if (!stall) begin
              ifid_valid <= 1'b1;
              ifid_instr <= skid_instr;
              ifid_pc4   <= skid_pc4;
              state      <= S_REQ;
            end
          end
          default: state <= S_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small in-order memory responder plus a linear
// sequence of steps checked on falling clock edges.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        stall;
  logic [1:0]  jump;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [5:0]  ifid_opcode;
  logic [5:0]  ifid_func;
  logic [31:0] ifid_pc4;
  logic        imem_timeout;

  int total = 0;
  int bad   = 0;

  int          lat  = 1;
  bit          hold = 1'b0;
  bit          pend = 1'b0;
  int          dly  = 0;
  logic [31:0] paddr = '0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .MAX_WAIT(8'd255)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .stall(stall), .jump(jump),
    .jump_index(jump_index), .jr_target(jr_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_opcode(ifid_opcode), .ifid_func(ifid_func),
    .ifid_pc4(ifid_pc4), .imem_timeout(imem_timeout)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory: one outstanding request, answered lat cycles after acceptance unless held.
  always @(posedge clk) begin
    logic        acc;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_req_addr;
    #1;
    imem_rsp_valid = 1'b0;
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (acc) begin
        pend  = 1'b1;
        dly   = lat;
        paddr = a;
      end
      if (pend && !hold) begin
        if (dly <= 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = word(paddr);
          pend           = 1'b0;
        end else begin
          dly = dly - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b1; stall = 1'b0; jump = 2'b00;
    jump_index = '0; jr_target = '0; branch_taken = 1'b0; branch_target = '0;
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_ifid_valid", {31'b0, ifid_valid}, 32'd0);
    chk("rst_ifid_instr", ifid_instr, 32'd0);
    chk("rst_ifid_pc4", ifid_pc4, 32'd0);
    chk("rst_timeout", {31'b0, imem_timeout}, 32'd0);

    // sequential fetch
    cyc(2); rst_n = 1'b1; #1;
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    cyc(1);
    chk("wait_no_req", {31'b0, imem_req_valid}, 32'd0);
    chk("wait_ifid_invalid", {31'b0, ifid_valid}, 32'd0);
    cyc(1);
    chk("a_valid", {31'b0, ifid_valid}, 32'd1);
    chk("a_instr", ifid_instr, 32'h5A5A_0000);
    chk("a_pc4", ifid_pc4, 32'h4);
    chk("a_opcode", {26'b0, ifid_opcode}, 32'h16);
    chk("b_req_addr", imem_req_addr, 32'h4);
    cyc(1);
    chk("bubble_valid", {31'b0, ifid_valid}, 32'd0);
    chk("bubble_instr", ifid_instr, 32'd0);
    cyc(1);
    chk("b_instr", ifid_instr, 32'h5A5A_0004);
    chk("b_pc4", ifid_pc4, 32'h8);
    chk("b_func", {26'b0, ifid_func}, 32'h4);
    chk("c_req_addr", imem_req_addr, 32'h8);

    // stall with response into skid
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("stall_hold_valid", {31'b0, ifid_valid}, 32'd1);
      chk("stall_hold_instr", ifid_instr, 32'h5A5A_0004);
      chk("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    stall = 1'b0;
    cyc(1);
    chk("skid_instr", ifid_instr, 32'h5A5A_0008);
    chk("skid_pc4", ifid_pc4, 32'hC);
    chk("skid_resume_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("skid_resume_addr", imem_req_addr, 32'hC);

    // branch in WAIT, late response dropped
    lat = 4;
    cyc(1);
    branch_taken = 1'b1; branch_target = 32'h100;
    cyc(1);
    branch_taken = 1'b0;
    chk("br_ifid_cleared", {31'b0, ifid_valid}, 32'd0);
    chk("br_still_wait", {31'b0, imem_req_valid}, 32'd0);
    cyc(2);
    chk("br_wait_squash", {31'b0, imem_req_valid}, 32'd0);
    cyc(1);
    chk("br_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("br_req_addr", imem_req_addr, 32'h100);
    chk("br_dropped", {31'b0, ifid_valid}, 32'd0);
    lat = 1;
    cyc(2);
    chk("br_word_pc4", ifid_pc4, 32'h104);

    // branch and jr together: branch wins
    branch_taken = 1'b1; branch_target = 32'h1000_0004; jump = 2'b10; jr_target = 32'h300;
    cyc(1);
    branch_taken = 1'b0; jump = 2'b00;
    chk("prio_ifid_cleared", {31'b0, ifid_valid}, 32'd0);
    cyc(1);
    chk("prio_req_addr", imem_req_addr, 32'h1000_0004);
    chk("prio_req_valid", {31'b0, imem_req_valid}, 32'd1);
    cyc(2);
    chk("prio_instr", ifid_instr, 32'h4A5A_0004);
    chk("prio_pc4", ifid_pc4, 32'h1000_0008);

    // j/jal and jr targets
    jump = 2'b01; jump_index = 26'h000040;
    cyc(1);
    jump = 2'b00;
    cyc(1);
    chk("j_req_addr", imem_req_addr, 32'h1000_0100);
    cyc(2);
    chk("j_pc4", ifid_pc4, 32'h1000_0104);
    jump = 2'b10; jr_target = 32'h203;
    cyc(1);
    jump = 2'b00;
    cyc(1);
    chk("jr_req_addr", imem_req_addr, 32'h200);

    // jump==11 is no redirect
    jump = 2'b11;
    cyc(1);
    jump = 2'b00;
    cyc(1);
    chk("j11_instr", ifid_instr, 32'h5A5A_0200);
    chk("j11_pc4", ifid_pc4, 32'h204);
    chk("j11_req_addr", imem_req_addr, 32'h204);

    // redirect under stall
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h400;
    cyc(1);
    branch_taken = 1'b0;
    chk("stbr_valid", {31'b0, ifid_valid}, 32'd0);
    chk("stbr_instr", ifid_instr, 32'd0);
    cyc(1);
    chk("stbr_req_addr", imem_req_addr, 32'h400);
    stall = 1'b0;
    cyc(2);
    chk("stbr_pc4", ifid_pc4, 32'h404);

    // pc wrap
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    cyc(1);
    branch_taken = 1'b0;
    cyc(1);
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    cyc(2);
    chk("wrap_instr", ifid_instr, 32'hA5A5_FFFC);
    chk("wrap_pc4", ifid_pc4, 32'h0);
    chk("wrap_next_addr", imem_req_addr, 32'h0);

    // timeout, stickiness, reset mid-WAIT
    hold = 1'b1;
    cyc(251);
    chk("timeout_early", {31'b0, imem_timeout}, 32'd0);
    cyc(10);
    chk("timeout_set", {31'b0, imem_timeout}, 32'd1);
    hold = 1'b0;
    cyc(2);
    chk("late_rsp_valid", {31'b0, ifid_valid}, 32'd1);
    chk("late_rsp_pc4", ifid_pc4, 32'h4);
    chk("timeout_sticky", {31'b0, imem_timeout}, 32'd1);
    stall = 1'b1; hold = 1'b1;
    cyc(1);
    chk("pre_rst_wait", {31'b0, imem_req_valid}, 32'd0);
    chk("pre_rst_ifid", {31'b0, ifid_valid}, 32'd1);
    rst_n = 1'b0; #1;
    chk("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("mid_rst_ifid_valid", {31'b0, ifid_valid}, 32'd0);
    chk("mid_rst_ifid_instr", ifid_instr, 32'd0);
    chk("mid_rst_ifid_pc4", ifid_pc4, 32'd0);
    chk("mid_rst_timeout", {31'b0, imem_timeout}, 32'd0);
    stall = 1'b0; hold = 1'b0;
    cyc(2);
    rst_n = 1'b1; #1;
    chk("post_rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("post_rst_req_addr", imem_req_addr, 32'h0);
    cyc(2);
    chk("post_rst_instr", ifid_instr, 32'h5A5A_0000);
    chk("post_rst_pc4", ifid_pc4, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
